// File: rtl/dram_ctrl_pkg.sv
// Shared types and encodings for the data-memory responder.
package dram_ctrl_pkg;
  typedef logic [31:0] MemBus;
  typedef logic [31:0] MemAddrBus;

  typedef enum logic [1:0] {
    DRAM_IDLE = 2'd0,
    DRAM_WAIT = 2'd1,
    DRAM_RESP = 2'd2
  } dram_state_e;

  localparam int DRAM_DEPTH = 4096;

  // word is the byte address with its two lane bits dropped
  typedef struct packed {
    logic        we;
    logic [29:0] word;
    MemBus       wdata;
    logic [3:0]  be;
  } dram_req_t;

  // Any set bit above the RAM index makes the access out of range
  function automatic logic out_of_range(input logic [29:0] word, input int aw);
    return |(word >> aw);
  endfunction
endpackage

// File: rtl/dram_ctrl_if.sv
// Request/response bus between the memory-access stage and dram_ctrl.
interface dram_ctrl_if;
  import dram_ctrl_pkg::*;

  logic       req_i;
  logic       we_i;
  MemAddrBus  addr_i;
  MemBus      wdata_i;
  logic [3:0] be_i;
  logic       gnt_o;
  logic       rvalid_o;
  MemBus      rdata_o;
  logic       err_o;

  modport master (output req_i, we_i, addr_i, wdata_i, be_i,
                  input  gnt_o, rvalid_o, rdata_o, err_o);
  modport slave  (input  req_i, we_i, addr_i, wdata_i, be_i,
                  output gnt_o, rvalid_o, rdata_o, err_o);
endinterface

// File: rtl/dram_ctrl_array.sv
// Word-organised data RAM, one byte-wide bank per lane, registered read port.
module dram_array
  import dram_ctrl_pkg::*;
#(
  parameter int DEPTH = DRAM_DEPTH,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [3:0]    be,
  input  logic          re,
  input  logic [AW-1:0] addr,
  input  MemBus         wdata,
  output MemBus         rdata
);
  logic [3:0][7:0] q;

  for (genvar l = 0; l < 4; l++) begin : g_lane
    logic [7:0] mem [DEPTH];
    logic [7:0] q_r;

    always_ff @(posedge clk) begin
      if (we && be[l]) mem[addr] <= wdata[8*l +: 8];
      if (re)          q_r       <= mem[addr];
    end

    assign q[l] = q_r;
  end

  assign rdata = q;
endmodule

// File: rtl/dram_ctrl.sv
// Single-outstanding load/store responder with programmable wait states in
// front of the internal data RAM.
module dram_ctrl
  import dram_ctrl_pkg::*;
#(
  parameter int DEPTH   = DRAM_DEPTH,
  parameter int LATENCY = 1
) (
  input logic        clk,
  input logic        rst,
  dram_ctrl_if.slave bus
);
  localparam int AW = $clog2(DEPTH);

  if (LATENCY < 1 || LATENCY > 15) begin : g_bad_latency
    $error("dram_ctrl: LATENCY must be 1..15");
  end
  if ((1 << AW) != DEPTH) begin : g_bad_depth
    $error("dram_ctrl: DEPTH must be a power of two");
  end

  dram_state_e state;
  logic [3:0]  cnt;
  dram_req_t   req_q;
  logic        gnt_q, rvalid_q, err_q, rd_ok_q;
  logic        access, oor;
  MemBus       arr_rdata;

  logic unused_addr_lsb;
  assign unused_addr_lsb = ^bus.addr_i[1:0];

  assign oor    = out_of_range(req_q.word, AW);
  assign access = (state == DRAM_WAIT) && (cnt == 4'd0);

  // gnt_q tracks "next state is IDLE" so it is low throughout reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= DRAM_IDLE;
      cnt      <= 4'd0;
      req_q    <= '0;
      gnt_q    <= 1'b0;
      rvalid_q <= 1'b0;
      err_q    <= 1'b0;
      rd_ok_q  <= 1'b0;
    end else begin
      unique case (state)
        DRAM_IDLE: begin
          gnt_q <= 1'b1;
          if (bus.req_i && gnt_q) begin
            req_q <= '{we: bus.we_i, word: bus.addr_i[31:2],
                       wdata: bus.wdata_i, be: bus.be_i};
            cnt   <= 4'(LATENCY - 1);
            gnt_q <= 1'b0;
            state <= DRAM_WAIT;
          end
        end
        DRAM_WAIT: begin
          if (cnt == 4'd0) begin
            rvalid_q <= 1'b1;
            err_q    <= oor;
            rd_ok_q  <= !req_q.we && !oor;
            state    <= DRAM_RESP;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        DRAM_RESP: begin
          rvalid_q <= 1'b0;
          err_q    <= 1'b0;
          rd_ok_q  <= 1'b0;
          gnt_q    <= 1'b1;
          state    <= DRAM_IDLE;
        end
        default: state <= DRAM_IDLE;
      endcase
    end
  end

  // RAM is touched only on the WAIT->RESP edge, never while reset holds IDLE
  dram_array #(.DEPTH(DEPTH), .AW(AW)) u_array (
    .clk   (clk),
    .we    (access && req_q.we && !oor),
    .be    (req_q.be),
    .re    (access && !req_q.we && !oor),
    .addr  (req_q.word[AW-1:0]),
    .wdata (req_q.wdata),
    .rdata (arr_rdata)
  );

  assign bus.gnt_o    = gnt_q;
  assign bus.rvalid_o = rvalid_q;
  assign bus.err_o    = err_q;
  assign bus.rdata_o  = rd_ok_q ? arr_rdata : '0;
endmodule
